// File: rtl/cfs_algn_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cfs_algn_stream_ctrl
//  Purpose  : Byte-stream aligner core. Collects unaligned input packets in a
//             2xB-byte circular staging buffer and emits packets of ctrl_size
//             bytes at byte lane ctrl_offset. Illegal inputs are dropped and
//             counted. An idle timer can flush a short tail of buffered bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module cfs_algn_stream_ctrl #(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int TIMEOUT_WIDTH   = 8,
  parameter  int CNT_WIDTH       = 8,
  localparam int C_BYTES         = ALGN_DATA_WIDTH / 8,
  localparam int C_OW            = ($clog2(C_BYTES) > 1) ? $clog2(C_BYTES) : 1,
  localparam int C_SW            = $clog2(C_BYTES) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // input packet stream
  input  logic                       in_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] in_data,
  input  logic [C_OW-1:0]            in_offset,
  input  logic [C_SW-1:0]            in_size,
  output logic                       in_ready,
  // aligned output stream
  output logic                       out_valid,
  output logic [ALGN_DATA_WIDTH-1:0] out_data,
  output logic [C_OW-1:0]            out_offset,
  output logic [C_SW-1:0]            out_size,
  input  logic                       out_ready,
  // configuration
  input  logic [C_OW-1:0]            ctrl_offset,
  input  logic [C_SW-1:0]            ctrl_size,
  input  logic                       ctrl_flush_en,
  input  logic [TIMEOUT_WIDTH-1:0]   ctrl_timeout,
  // status
  input  logic                       status_clr,
  output logic [CNT_WIDTH-1:0]       cnt_drop,
  output logic [C_SW:0]              buf_level
);

  // Level needs one bit more than a size to hold up to 2B bytes.
  localparam int C_LW    = C_SW + 1;
  localparam int C_DEPTH = 2 * C_BYTES;
  localparam int C_PW    = $clog2(C_DEPTH);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [7:0]                 r_mem [C_DEPTH];
  logic [C_PW-1:0]            r_rd_ptr;
  logic [C_PW-1:0]            r_wr_ptr;
  logic [C_LW-1:0]            r_level;
  logic [TIMEOUT_WIDTH-1:0]   r_timer;
  logic [CNT_WIDTH-1:0]       r_cnt_drop;
  logic                       r_out_valid;
  logic [ALGN_DATA_WIDTH-1:0] r_out_data;
  logic [C_OW-1:0]            r_out_offset;
  logic [C_SW-1:0]            r_out_size;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                       w_in_hs;
  logic [C_LW-1:0]            w_in_end;
  logic                       w_in_legal;
  logic [C_LW-1:0]            w_wr_cnt;
  logic [ALGN_DATA_WIDTH-1:0] w_in_shift;
  logic [C_LW-1:0]            w_cfg_end;
  logic                       w_cfg_legal;
  logic                       w_stage_free;
  logic                       w_load_full;
  logic                       w_flush_cond;
  logic                       w_load_flush;
  logic [C_LW-1:0]            w_pop_cnt;
  logic [ALGN_DATA_WIDTH-1:0] w_pop_word;
  logic [ALGN_DATA_WIDTH-1:0] w_out_word;

  // Ready comes from the registered level only: with at most B bytes held,
  // any legal input (at most B bytes) is guaranteed to fit in 2B.
  assign in_ready   = (r_level <= C_LW'(C_BYTES));
  assign w_in_hs    = in_valid & in_ready;

  // An input is legal when it carries bytes and they stay inside the word.
  assign w_in_end   = C_LW'(in_offset) + C_LW'(in_size);
  assign w_in_legal = (in_size != '0) && (w_in_end <= C_LW'(C_BYTES));
  assign w_wr_cnt   = (w_in_hs && w_in_legal) ? C_LW'(in_size) : '0;

  // Move the first valid input byte down to lane 0 so byte j is written to
  // buffer slot wr_ptr+j.
  assign w_in_shift = in_data >> {in_offset, 3'b000};

  // Same legality rule for the target packet shape.
  assign w_cfg_end   = C_LW'(ctrl_offset) + C_LW'(ctrl_size);
  assign w_cfg_legal = (ctrl_size != '0) && (w_cfg_end <= C_LW'(C_BYTES));

  // The output register may be reloaded when empty or being consumed now.
  assign w_stage_free = ~r_out_valid | out_ready;

  // Full packets take priority; a flush only drains a tail shorter than a
  // full packet once the idle timer has reached the programmed timeout.
  assign w_load_full  = w_stage_free && w_cfg_legal &&
                        (r_level >= C_LW'(ctrl_size));
  assign w_flush_cond = ctrl_flush_en && (ctrl_timeout != '0) && w_cfg_legal &&
                        (r_level != '0) && (r_level < C_LW'(ctrl_size)) &&
                        (r_timer == ctrl_timeout);
  assign w_load_flush = w_stage_free && !w_load_full && w_flush_cond;

  assign w_pop_cnt = w_load_full  ? C_LW'(ctrl_size) :
                     w_load_flush ? r_level          : '0;

  // Gather the popped bytes into lanes 0..pop_cnt-1; unused lanes stay zero.
  always_comb begin
    w_pop_word = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      if (C_LW'(i) < w_pop_cnt) begin
        w_pop_word[i*8 +: 8] = r_mem[r_rd_ptr + C_PW'(i)];
      end
    end
  end

  // Place the packet at the target lane. Legal config keeps it inside the word.
  assign w_out_word = w_pop_word << {ctrl_offset, 3'b000};

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Staging buffer storage: write accepted bytes in ascending lane order.
  always_ff @(posedge clk) begin
    for (int j = 0; j < C_BYTES; j++) begin
      if (C_LW'(j) < w_wr_cnt) begin
        r_mem[r_wr_ptr + C_PW'(j)] <= w_in_shift[j*8 +: 8];
      end
    end
  end

  // Pointers and level; a simultaneous write and pop net out in the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_wr_cnt[C_PW-1:0];
      r_rd_ptr <= r_rd_ptr + w_pop_cnt[C_PW-1:0];
      r_level  <= r_level + w_wr_cnt - w_pop_cnt;
    end
  end

  // Idle timer: restarts on traffic, an empty buffer or a flush, and
  // otherwise counts up and parks at the programmed timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_in_hs || (r_level == '0) || w_load_flush) begin
      r_timer <= '0;
    end else if (r_timer < ctrl_timeout) begin
      r_timer <= r_timer + TIMEOUT_WIDTH'(1);
    end
  end

  // Drop counter: clear wins over a coincident drop; saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_drop <= '0;
    end else if (status_clr) begin
      r_cnt_drop <= '0;
    end else if (w_in_hs && !w_in_legal && !(&r_cnt_drop)) begin
      r_cnt_drop <= r_cnt_drop + CNT_WIDTH'(1);
    end
  end

  // Output register: reload when free, otherwise hold the stalled packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_offset <= '0;
      r_out_size   <= '0;
    end else if (w_stage_free) begin
      if (w_load_full || w_load_flush) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_out_word;
        r_out_offset <= ctrl_offset;
        r_out_size   <= w_pop_cnt[C_SW-1:0];
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_offset = r_out_offset;
  assign out_size   = r_out_size;
  assign cnt_drop   = r_cnt_drop;
  assign buf_level  = r_level;

endmodule
`default_nettype wire

// File: doc/cfs_algn_stream_ctrl.md
# cfs_algn_stream_ctrl

Parametrised byte-stream aligner core. It sits between the RX FIFO and the TX FIFO of the aligner datapath. It accepts unaligned packets (data, offset, size) into a 2×B-byte staging buffer and repacks them into packets of `ctrl_size` bytes placed at byte lane `ctrl_offset`. Compared with the fixed controller it adds input legality checking with a drop counter, a timeout-driven partial flush, and full-throughput back-to-back output.

## Interface
Derived values: B = ALGN_DATA_WIDTH/8; OW = max(1, clog2(B)); SW = clog2(B)+1.

Parameters:
- ALGN_DATA_WIDTH, 32: data width in bits; multiple of 8, ≥16, power of two.
- TIMEOUT_WIDTH, 8: width of the flush idle timer.
- CNT_WIDTH, 8: width of the drop counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input packet valid
- in_data  in  ALGN_DATA_WIDTH  input data, byte lanes
- in_offset  in  OW  first valid input byte lane
- in_size  in  SW  number of valid input bytes
- in_ready  out  1  input accept
- out_valid  out  1  aligned packet valid
- out_data  out  ALGN_DATA_WIDTH  aligned data; lanes outside the packet are zero
- out_offset  out  OW  output byte lane
- out_size  out  SW  output byte count
- out_ready  in  1  output accept
- ctrl_offset  in  OW  target lane
- ctrl_size  in  SW  target size
- ctrl_flush_en  in  1  enable timeout flush
- ctrl_timeout  in  TIMEOUT_WIDTH  idle cycles before a flush; 0 disables flush
- status_clr  in  1  synchronous clear of cnt_drop
- cnt_drop  out  CNT_WIDTH  saturating count of dropped illegal inputs
- buf_level  out  SW+1  bytes currently held in the staging buffer

## Operation
- The staging buffer is a 2B-byte circular byte FIFO with a read pointer, a write pointer and `level`. `buf_level` = `level`.
- `in_ready` = (`level` ≤ B), taken from the registered level. This guarantees any legal input fits.
- Input handshake (`in_valid` & `in_ready`):
  - Legal input (`in_size` ≠ 0 and `in_offset` + `in_size` ≤ B): bytes `in_offset` .. `in_offset`+`in_size`−1 are written in ascending lane order.
  - Illegal input: the input is consumed but not written, and `cnt_drop` increments, saturating at all-ones.
- Config is legal when `ctrl_size` ≠ 0 and `ctrl_offset` + `ctrl_size` ≤ B. While config is illegal, no output is loaded, and the buffer fills until `in_ready` drops.
- The output stage is a single register. It is "free" when `out_valid` = 0 or `out_ready` = 1. At an edge where the stage is free:
  - Load a full packet if config is legal and `level` ≥ `ctrl_size`. Pop `ctrl_size` bytes and place buffer byte i at lane `ctrl_offset`+i. Set `out_size` = `ctrl_size` and `out_offset` = `ctrl_offset`.
  - Otherwise load a flush packet if the flush condition holds. Pop all `level` bytes and set `out_size` = `level`, placing them at `ctrl_offset`.
  - Otherwise clear `out_valid`.
- Flush condition: `ctrl_flush_en` = 1, `ctrl_timeout` ≠ 0, config legal, 0 < `level` < `ctrl_size`, and idle timer = `ctrl_timeout`.
- Idle timer:
  - Resets to 0 on any input handshake, when `level` = 0, or on a flush load.
  - Otherwise increments, saturating at `ctrl_timeout`.
- When read and write occur at the same edge: `level_next` = `level` + bytes written − bytes popped.
- `ctrl_*` are sampled only at load. Bytes already in the buffer are preserved across config changes.
- `status_clr` has priority over a simultaneous drop: the counter becomes 0.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `out_data` 0, `out_offset` 0, `out_size` 0, `cnt_drop` 0, `buf_level` 0, idle timer 0, pointers 0. Reset mid-packet discards all buffered bytes and any pending output.
- Latency: an input handshake at edge k updates `level` after edge k. The output loads at edge k+1, so `out_valid` is high 2 cycles after the input handshake.
- Throughput: one output per cycle while `level` ≥ `ctrl_size` and `out_ready` = 1.
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_offset` and `out_size` hold stable.
- A flush fires at the edge where the timer equals `ctrl_timeout`, i.e. `ctrl_timeout`+1 edges after the last write. It has lower priority than a full packet.

## Test plan
All scenarios use B = 4.
- Split: ctrl 2/0; input 0xDDCCBBAA, size 4, offset 0 → outputs 0x0000BBAA then 0x0000DDCC, both size 2 offset 0, on consecutive cycles.
- Merge: ctrl 4/0; input 0x11000000 size 1 offset 3, then 0x00443322 size 3 offset 0 → one output 0x44332211 size 4.
- Backpressure: ctrl 1/2, continuous size-4 inputs, `out_ready` low for 10 cycles → output held stable, `in_ready` low once `level` > 4, all bytes emitted in order afterwards with no loss.
- Illegal input: size 3 offset 2 → no output, `buf_level` stays 0, `cnt_drop` = 1. Then `status_clr` → `cnt_drop` = 0.
- Flush: ctrl 2/2, `ctrl_flush_en` = 1, `ctrl_timeout` 5; input 0xAB size 1 offset 0, then idle → output 0x00AB0000 with size 1 offset 2 at the 6th edge after the write. Repeat with `ctrl_flush_en` = 0 → no output.
- Reset mid-operation: `level` 3 with `out_valid` held → assert `reset_n` = 0 → all outputs return to reset values and `in_ready` = 1. After release, a fresh legal stream aligns correctly.
